// File: rtl/pio_edge_capture_in.sv
// pio_edge_capture_in: synchronised PIO input port with edge capture, interrupt mask and 1-cycle registered reads.
module pio_edge_capture_in #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = $clog2(SYNC_STAGES + 2);
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q, sync_prev, edge_det, edgecapture, interruptmask, clr;
    logic [CW-1:0]    warm;
    logic             armed, wr_en;
    logic [31:0]      rd_next;
    assign sync_q = sync_r[SYNC_STAGES-1];
    // Edges are ignored until the chain and sync_prev hold post-reset samples only.
    assign armed  = warm == CW'(SYNC_STAGES + 1);
    assign wr_en  = chipselect & write;
    always_comb begin
        edge_det = '0;
        if (armed)
            edge_det = EDGE_TYPE == 0 ? sync_q & ~sync_prev :
                       EDGE_TYPE == 1 ? ~sync_q & sync_prev : sync_q ^ sync_prev;
        clr = wr_en && address == 2'd3 ? writedata[WIDTH-1:0] : '0;
        rd_next = address == 2'd0 ? 32'(sync_q) :
                  address == 2'd2 ? 32'(interruptmask) :
                  address == 2'd3 ? 32'(edgecapture) : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
            sync_prev     <= '0;
            warm          <= '0;
            edgecapture   <= '0;
            interruptmask <= '0;
            readdata      <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            sync_prev <= sync_q;
            if (!armed) warm <= warm + 1'b1;
            edgecapture <= (edgecapture & ~clr) | edge_det;
            if (wr_en && address == 2'd2) interruptmask <= writedata[WIDTH-1:0];
            readdata <= rd_next;
        end
    end
    assign irq = |((IRQ_MODE != 0 ? sync_q : edgecapture) & interruptmask);
endmodule

// File: tb/tb_pio_edge_capture_in.sv
// tb_pio_edge_capture_in: scoreboard bench driving four parameter variants with shared stimulus.
module tb_pio_edge_capture_in;
    localparam logic [3:0][3:0] S_P = {4'd3, 4'd2, 4'd2, 4'd2};
    localparam logic [3:0][3:0] E_P = {4'd2, 4'd2, 4'd1, 4'd0};
    localparam logic [3:0][3:0] I_P = {4'd0, 4'd1, 4'd0, 4'd0};
    typedef struct packed {
        logic [3:0][31:0] rd;
        logic [3:0]       irq;
    } exp_t;
    logic        clk = 0, reset = 1, chipselect = 0, write = 0;
    logic [1:0]  address = 0;
    logic [31:0] writedata = 0;
    logic [3:0]  in_port = 0;
    logic [31:0] rd [4];
    logic [3:0]  irq_v;
    logic [3:0]  ec [4], mk [4];
    logic [3:0]  samp [$];
    exp_t        q [$];
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        pio_edge_capture_in #(.WIDTH(4), .SYNC_STAGES(int'(S_P[g])), .EDGE_TYPE(int'(E_P[g])),
                              .IRQ_MODE(int'(I_P[g]))) dut (
            .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
            .writedata(writedata), .in_port(in_port), .readdata(rd[g]), .irq(irq_v[g]));
    end
    // v(n) is the in_port value sampled at the n-th edge since reset (0 before the first).
    function automatic logic [3:0] v(int n);
        return (n >= 1 && n <= samp.size()) ? samp[n-1] : 4'h0;
    endfunction
    task automatic model();
        exp_t e;
        int k, s;
        logic [3:0] a, b, set;
        e = '0;
        if (reset) begin
            samp.delete();
            for (int i = 0; i < 4; i++) begin ec[i] = 0; mk[i] = 0; end
        end else begin
            k = samp.size() + 1;
            for (int i = 0; i < 4; i++) begin
                s = int'(S_P[i]);
                e.rd[i] = address == 2'd0 ? 32'(v(k - s)) : address == 2'd2 ? 32'(mk[i]) :
                          address == 2'd3 ? 32'(ec[i]) : 32'd0;
                set = 0;
                // A capture is two consecutive post-reset samples that differ, seen SYNC_STAGES edges later.
                if (k - s - 1 >= 1) begin
                    a = v(k - s);
                    b = v(k - s - 1);
                    set = E_P[i] == 0 ? a & ~b : E_P[i] == 1 ? ~a & b : a ^ b;
                end
                if (chipselect && write && address == 2'd3) ec[i] = ec[i] & ~writedata[3:0];
                ec[i] = ec[i] | set;
                if (chipselect && write && address == 2'd2) mk[i] = writedata[3:0];
            end
            samp.push_back(in_port);
            for (int i = 0; i < 4; i++)
                e.irq[i] = |((I_P[i] != 0 ? v(k + 1 - int'(S_P[i])) : ec[i]) & mk[i]);
        end
        q.push_back(e);
    endtask
    task automatic cyc(input logic r, input logic c, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic [3:0] p);
        reset = r; chipselect = c; write = w; address = a; writedata = d; in_port = p;
        @(posedge clk);
        #1;
        model();
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== e.rd[i]) begin
                    errors++;
                    $display("FAIL readdata[%0d] t=%0t: got %h expected %h", i, $time, rd[i], e.rd[i]);
                end
                checks++;
                if (irq_v[i] !== e.irq[i]) begin
                    errors++;
                    $display("FAIL irq[%0d] t=%0t: got %b expected %b", i, $time, irq_v[i], e.irq[i]);
                end
            end
        end
    end
    initial begin
        logic [3:0] p;
        repeat (2) cyc(1, 0, 0, 3, 0, 4'hF);
        repeat (6) cyc(0, 0, 0, 3, 0, 4'hF);
        repeat (4) cyc(0, 0, 0, 0, 0, 4'hF);
        cyc(0, 1, 1, 3, 32'hF, 4'h0);
        repeat (6) cyc(0, 0, 0, 3, 0, 4'h0);
        cyc(0, 1, 1, 3, 32'hF, 4'h0);
        cyc(0, 1, 1, 2, 32'h4, 4'h0);
        repeat (6) cyc(0, 0, 0, 3, 0, 4'h5);
        cyc(0, 1, 1, 3, 32'h4, 4'h5);
        repeat (3) cyc(0, 0, 0, 3, 0, 4'h5);
        repeat (5) cyc(0, 1, 1, 3, 32'hF, 4'h4);
        repeat (2) cyc(0, 0, 0, 3, 0, 4'h5);
        cyc(0, 1, 1, 3, 32'h1, 4'h5);
        repeat (3) cyc(0, 0, 0, 3, 0, 4'h5);
        cyc(0, 1, 1, 3, 32'hF, 4'h5);
        repeat (4) cyc(0, 0, 0, 3, 0, 4'h7);
        repeat (4) cyc(0, 0, 0, 3, 0, 4'h5);
        cyc(0, 1, 1, 2, 32'h1, 4'h5);
        repeat (4) cyc(0, 0, 0, 0, 0, 4'h4);
        repeat (4) cyc(0, 0, 0, 0, 0, 4'h5);
        cyc(0, 1, 1, 2, 32'hF, 4'h0);
        repeat (4) cyc(0, 0, 0, 3, 0, 4'hF);
        repeat (4) cyc(0, 0, 0, 2, 0, 4'h0);
        cyc(1, 0, 0, 3, 0, 4'hF);
        repeat (6) cyc(0, 0, 0, 3, 0, 4'hF);
        repeat (2) cyc(0, 0, 0, 2, 0, 4'hF);
        p = 4'hF;
        repeat (1500) begin
            if ($urandom_range(0, 2) == 0) p = 4'($urandom);
            cyc($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom), 2'($urandom), $urandom, p);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
